// File: rtl/mem_arbiter_if.sv
// Requester-side bus of mem_arbiter: per-requester request/address/data in, ack/rdata/grant out.
// Latency: none, wires only.
// Backpressure: requesters hold req and its fields until the matching ack pulse.
`ifndef WIDTH
`define WIDTH 10
`endif
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 64
`endif

interface mem_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ*`WIDTH-1:0]      req_addr;
    logic [NUM_REQ*`BLOCK_SIZE-1:0] req_wdata;
    logic [NUM_REQ-1:0]             ack;
    logic [`BLOCK_SIZE-1:0]         rdata;
    logic [ID_W-1:0]                gnt_id;
    logic                           busy;

    // Requesters drive the request side and observe completion.
    modport master (
        output req, req_we, req_addr, req_wdata,
        input  ack, rdata, gnt_id, busy
    );

    // The arbiter consumes requests and reports completion.
    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output ack, rdata, gnt_id, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin sharing of one single-port block memory among NUM_REQ requesters (MEM_ARB_FIXED_PRIO_EN: lowest index wins).
// Latency: req seen in IDLE at t -> memory held t+1..t+ACCESS_CYCLES -> one-cycle ack at t+ACCESS_CYCLES+1.
// Backpressure: one transaction in flight; losers simply keep req high until their ack.
`ifndef WIDTH
`define WIDTH 10
`endif
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 64
`endif

module mem_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    mem_arbiter_if.slave           bus,
    output logic                   memRead_en,
    output logic                   memWrite_en,
    output logic [`WIDTH-1:0]      mem_address,
    output logic [`BLOCK_SIZE-1:0] memWrite_data,
    input  logic [`BLOCK_SIZE-1:0] memRead_data
);
    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [3:0]      CNT_LOAD = 4'(ACCESS_CYCLES - 1);
    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);

    logic [1:0]             state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ID_W-1:0]        gnt_id_q, gnt_id_d;
    logic                   we_q, we_d;
    logic [`WIDTH-1:0]      addr_q, addr_d;
    logic [`BLOCK_SIZE-1:0] wdata_q, wdata_d;
    logic [`BLOCK_SIZE-1:0] rdata_q, rdata_d;

    logic                   win_vld;
    logic [ID_W-1:0]        win_id;

    // Pick the winner among the raised requests.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        // Scan downward so the lowest raised index is the last one kept.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(i);
            end
        end
`else
        // Scan offsets downward so the request closest after rr_ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (bus.req[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
`endif
    end

    // Sequencing: latch the winner, hold the memory port, then acknowledge.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        gnt_id_d = gnt_id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    gnt_id_d = win_id;
                    we_d     = bus.req_we[win_id];
                    addr_d   = bus.req_addr[win_id*`WIDTH +: `WIDTH];
                    wdata_d  = bus.req_wdata[win_id*`BLOCK_SIZE +: `BLOCK_SIZE];
                    cnt_d    = CNT_LOAD;
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        rdata_d = memRead_data;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                rr_ptr_d = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + ID_W'(1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops any transaction in flight without an ack.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            gnt_id_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            gnt_id_q <= gnt_id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Enables decode from registered state, so reset kills them immediately.
    // A write strobes only on the last access cycle to give exactly one write edge.
    assign memRead_en    = (state_q == S_ACCESS) && !we_q;
    assign memWrite_en   = (state_q == S_ACCESS) && we_q && (cnt_q == 4'd0);
    assign mem_address   = addr_q;
    assign memWrite_data = wdata_q;

    assign bus.ack    = (state_q == S_RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id_q) : '0;
    assign bus.rdata  = rdata_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = (state_q != S_IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single-port block memory (1024 x `BLOCK_SIZE`, combinational read, clocked write) between NUM_REQ requesters (per-core caches plus directory).
- Accepts one transaction at a time, drives the memory control/address/data ports, and captures read data.
- Returns completion to the granted requester with a one-cycle ack pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID_W = clog2(NUM_REQ), derived.
- ACCESS_CYCLES, 1, cycles the memory port is held per access (1..15); 4-bit counter.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  request per requester; level, held until ack
- req_we  in  NUM_REQ  1 = write, 0 = read; per requester
- req_addr  in  NUM_REQ*`WIDTH  flattened addresses; slice i = bits [i*`WIDTH +: `WIDTH]
- req_wdata  in  NUM_REQ*`BLOCK_SIZE  flattened write blocks
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot or zero
- rdata  out  `BLOCK_SIZE  read data, valid in the ack cycle, held until next read ack
- gnt_id  out  ID_W  index of the current/last granted requester
- busy  out  1  high while not IDLE
- memRead_en  out  1  to memory
- memWrite_en  out  1  to memory
- mem_address  out  `WIDTH  to memory, registered
- memWrite_data  out  `BLOCK_SIZE  to memory, registered
- memRead_data  in  `BLOCK_SIZE  from memory

Behaviour:
- Reset (async, any state): state=IDLE; rr_ptr=0; ack, rdata, gnt_id, busy, memRead_en, memWrite_en, mem_address, memWrite_data all 0.
- Reset mid-operation aborts the transaction with no ack. No memWrite_en is seen at a clock edge after reset assertion.
- FSM IDLE:
  - If |req, pick the first set req scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Latch gnt_id, req_we, addr and wdata of the winner; load cnt=ACCESS_CYCLES-1; go to ACCESS.
- FSM ACCESS:
  - mem_address and memWrite_data come from latches.
  - Read: memRead_en=1 for all ACCESS cycles.
  - Write: memWrite_en=1 only in the final ACCESS cycle (cnt==0), giving exactly one write edge.
  - cnt decrements each cycle. At cnt==0: read captures memRead_data into rdata; go to RESP.
- FSM RESP:
  - ack[gnt_id]=1 for exactly one cycle; memRead_en=memWrite_en=0.
  - rr_ptr = gnt_id+1, wrapping NUM_REQ-1 -> 0; go to IDLE.
- Latency: req sampled high in IDLE cycle t -> ACCESS cycles t+1..t+ACCESS_CYCLES -> ack high in cycle t+ACCESS_CYCLES+1.
- Throughput: one transaction per ACCESS_CYCLES+2 cycles. IDLE is always visited once between transactions.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack.
  - Deassert req in the cycle after ack; a req still high is treated as a new request.
  - Dropping req after grant does not cancel: the access completes and ack still pulses.
- Writes leave rdata unchanged. Inputs of non-granted requesters are ignored.
- Simultaneous requests: exactly one grant per IDLE cycle. Others wait, and no requester waits more than NUM_REQ-1 transactions (round-robin).
- No req: stays in IDLE, memory enables low, outputs hold.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: rr_ptr is not used; the lowest-index set req always wins. Starvation is permitted (directory at index 0 gets absolute priority).
- Undefined: round-robin as specified above.

Test Plan:
- Single read: req[1]=1, we=0, addr block 5 (memory init 1) -> ack[1] high exactly 2 cycles after the req cycle (ACCESS_CYCLES=1); rdata=1; gnt_id=1; memWrite_en never high.
- Write then read: req[2] writes 64'hDEAD_BEEF_0123_4567 to block 9, then reads it back -> exactly one memWrite_en pulse; read ack rdata=64'hDEAD_BEEF_0123_4567.
- Contention: req=4'b1111 held, each deasserting after its ack -> ack order 0,1,2,3; 4 acks spaced 3 cycles apart; with MEM_ARB_FIXED_PRIO_EN and req[0] re-raised every time -> only ack[0] pulses.
- Wrap fairness: rr_ptr=3 after serving 2, req=4'b1001 -> 3 is served first, then 0.
- Mid-write reset: ACCESS_CYCLES=4, write issued, sys_rst_n low in the 2nd ACCESS cycle -> no memWrite_en at any edge, block unchanged, no ack, all outputs 0 and busy=0.
- Withdrawn request: req[3] dropped one cycle after grant -> ack[3] still pulses; next IDLE with req=0 stays idle.
